// File: rtl/reg_pkg.sv
// Shared constants, types and helpers for the register-file write scheduler.
// Addresses carry one extra MSB: a set MSB marks an out-of-range register.
package reg_pkg;

    localparam int PW       = 3;
    localparam int DW       = 8;
    localparam int NUM_REGS = 2 ** PW;
    localparam int IMM_REG  = NUM_REGS - 1;

    typedef struct packed {
        logic [PW:0]   addr;
        logic [DW-1:0] data;
    } wb_req_t;

    function automatic logic in_range(input logic [PW:0] addr);
        return !addr[PW];
    endfunction

endpackage

// File: rtl/reg_wr_sched_rr_arb2.sv
// Two-way round-robin arbiter for the writeback requesters.
// A lone valid requester always wins; on contention the requester named by
// prio wins, and prio then points at the loser so it goes first next time.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic prio_q;
    logic prio_d;

    // Grant selection and the priority pointer update that follows a grant.
    always_comb begin
        grant  = 2'b00;
        prio_d = prio_q;
        if (rst_n) begin
            unique case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = prio_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
        if (grant[0]) begin
            prio_d = 1'b1;
        end else if (grant[1]) begin
            prio_d = 1'b0;
        end
    end

    // Priority pointer register; reset favours requester 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/reg_wr_sched.sv
// Write-port scheduler and pending-write scoreboard for the register file.
// Arbitrates two writeback sources onto the single registered write port and
// tracks reserved destination registers so decode can detect RAW/WAW hazards.
module reg_wr_sched
    import reg_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req_valid,
    input  logic [PW:0]   req_addr0,
    input  logic [PW:0]   req_addr1,
    input  logic [DW-1:0] req_data0,
    input  logic [DW-1:0] req_data1,
    output logic [1:0]    req_ready,
    input  logic          rsv_valid,
    input  logic [PW:0]   rsv_addr,
    output logic          rsv_ready,
    input  logic [PW:0]   rd_addrA,
    input  logic [PW:0]   rd_addrB,
    output logic          haz_a,
    output logic          haz_b,
    output logic          rf_wr_en,
    output logic [PW:0]   rf_wr_addr,
    output logic [DW-1:0] rf_dat_out,
    output logic          err_addr
);

    logic [1:0]          grant;
    logic                accept;
    logic                rsvTake;
    wb_req_t             selReq;
    logic                wrEn_d;
    logic                wrEn_q;
    logic [PW:0]         wrAddr_q;
    logic [DW-1:0]       wrData_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] busy_q;
    logic                err_d;
    logic                err_q;
    logic [PW-1:0]       rsvIdx;
    logic [PW-1:0]       rdIdxA;
    logic [PW-1:0]       rdIdxB;
    logic [PW-1:0]       wrIdx;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (req_valid),
        .grant (grant)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    assign rsvIdx = rsv_addr[PW-1:0];
    assign rdIdxA = rd_addrA[PW-1:0];
    assign rdIdxB = rd_addrB[PW-1:0];
    assign wrIdx  = wrAddr_q[PW-1:0];

    assign rsv_ready = rst_n && (!in_range(rsv_addr) || !busy_q[rsvIdx]);
    assign rsvTake   = rsv_valid && rsv_ready;

    assign haz_a = in_range(rd_addrA) && busy_q[rdIdxA];
    assign haz_b = in_range(rd_addrB) && busy_q[rdIdxB];

    // Route the granted requester's payload toward the write stage.
    always_comb begin
        selReq.addr = req_addr0;
        selReq.data = req_data0;
        if (grant[1]) begin
            selReq.addr = req_addr1;
            selReq.data = req_data1;
        end
    end

    // Out-of-range accepts are consumed but never reach the file.
    assign wrEn_d = accept && in_range(selReq.addr);

    // Registered write port; addr/data only move on an issued write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrEn_q   <= 1'b0;
            wrAddr_q <= '0;
            wrData_q <= '0;
        end else begin
            wrEn_q <= wrEn_d;
            if (wrEn_d) begin
                wrAddr_q <= selReq.addr;
                wrData_q <= selReq.data;
            end
        end
    end

    // Scoreboard next state: completing write clears, new reservation sets and wins.
    always_comb begin
        busy_d = busy_q;
        if (wrEn_q) begin
            busy_d[wrIdx] = 1'b0;
        end
        if (rsvTake && in_range(rsv_addr)) begin
            busy_d[rsvIdx] = 1'b1;
        end
    end

    // Sticky error on any handshaked request or reservation naming a bad register.
    always_comb begin
        err_d = err_q;
        if (accept && !in_range(selReq.addr)) begin
            err_d = 1'b1;
        end
        if (rsvTake && !in_range(rsv_addr)) begin
            err_d = 1'b1;
        end
    end

    // Scoreboard and error flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign rf_wr_en   = wrEn_q;
    assign rf_wr_addr = wrAddr_q;
    assign rf_dat_out = wrData_q;
    assign err_addr   = err_q;

endmodule

// File: tb/tb_reg_wr_sched.sv
// Self-checking bench for reg_wr_sched: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// behavioural model of the scheduler kept in this file.
module tb_reg_wr_sched;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [3:0] req_addr0;
    logic [3:0] req_addr1;
    logic [7:0] req_data0;
    logic [7:0] req_data1;
    logic [1:0] req_ready;
    logic       rsv_valid;
    logic [3:0] rsv_addr;
    logic       rsv_ready;
    logic [3:0] rd_addrA;
    logic [3:0] rd_addrB;
    logic       haz_a;
    logic       haz_b;
    logic       rf_wr_en;
    logic [3:0] rf_wr_addr;
    logic [7:0] rf_dat_out;
    logic       err_addr;

    int compared   = 0;
    int mismatched = 0;

    reg_wr_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_data0  (req_data0),
        .req_data1  (req_data1),
        .req_ready  (req_ready),
        .rsv_valid  (rsv_valid),
        .rsv_addr   (rsv_addr),
        .rsv_ready  (rsv_ready),
        .rd_addrA   (rd_addrA),
        .rd_addrB   (rd_addrB),
        .haz_a      (haz_a),
        .haz_b      (haz_b),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_dat_out (rf_dat_out),
        .err_addr   (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state: which registers await a write, who has
    // priority, what the write port shows, and the sticky error.
    bit         mBusy [8];
    int         mPrio     = 0;
    bit         mWrEn     = 0;
    logic [3:0] mWrAddr   = 4'd0;
    logic [7:0] mWrData   = 8'd0;
    bit         mErr      = 0;
    bit         modelLive = 0;
    logic [1:0] lastGrant = 2'b00;

    function automatic logic [1:0] modelGrant();
        if (!rst_n) return 2'b00;
        if (req_valid == 2'b11) return (mPrio == 0) ? 2'b01 : 2'b10;
        return req_valid;
    endfunction

    function automatic bit modelRsvReady();
        if (!rst_n) return 1'b0;
        if (rsv_addr >= 4'd8) return 1'b1;
        return !mBusy[rsv_addr[2:0]];
    endfunction

    function automatic bit modelHaz(input logic [3:0] a);
        if (a >= 4'd8) return 1'b0;
        return mBusy[a[2:0]];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model across one clock edge using the inputs seen there.
    always @(posedge clk) begin
        logic [1:0] g;
        bit         rOk;
        bit         nextEn;
        int         gi;
        logic [3:0] a;
        logic [7:0] d;
        g   = modelGrant();
        rOk = modelRsvReady();
        lastGrant = g;
        if (!rst_n) begin
            foreach (mBusy[i]) mBusy[i] = 1'b0;
            mPrio     = 0;
            mWrEn     = 1'b0;
            mWrAddr   = 4'd0;
            mWrData   = 8'd0;
            mErr      = 1'b0;
            modelLive = 1'b1;
        end else begin
            if (mWrEn) mBusy[mWrAddr[2:0]] = 1'b0;
            if (rsv_valid && rOk && rsv_addr < 4'd8) mBusy[rsv_addr[2:0]] = 1'b1;
            if (rsv_valid && rOk && rsv_addr >= 4'd8) mErr = 1'b1;
            nextEn = 1'b0;
            if (g != 2'b00) begin
                gi = g[1] ? 1 : 0;
                a  = (gi == 1) ? req_addr1 : req_addr0;
                d  = (gi == 1) ? req_data1 : req_data0;
                if (a < 4'd8) begin
                    nextEn  = 1'b1;
                    mWrAddr = a;
                    mWrData = d;
                end else begin
                    mErr = 1'b1;
                end
                mPrio = 1 - gi;
            end
            mWrEn = nextEn;
        end
    end

    // Compare every visible output with the model in the middle of each cycle.
    always @(negedge clk) begin
        if (modelLive) begin
            checkOutput("req_ready", req_ready, modelGrant());
            checkOutput("rsv_ready", rsv_ready, modelRsvReady());
            checkOutput("haz_a", haz_a, modelHaz(rd_addrA));
            checkOutput("haz_b", haz_b, modelHaz(rd_addrB));
            checkOutput("rf_wr_en", rf_wr_en, mWrEn);
            if (mWrEn) begin
                checkOutput("rf_wr_addr", rf_wr_addr, mWrAddr);
                checkOutput("rf_dat_out", rf_dat_out, mWrData);
            end
            checkOutput("err_addr", err_addr, mErr);
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic atSample();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [1:0] v, input logic [3:0] a0, input logic [7:0] d0,
                                 input logic [3:0] a1, input logic [7:0] d1,
                                 input logic rv, input logic [3:0] ra,
                                 input logic [3:0] rdA, input logic [3:0] rdB);
        req_valid = v;
        req_addr0 = a0;
        req_data0 = d0;
        req_addr1 = a1;
        req_data1 = d1;
        rsv_valid = rv;
        rsv_addr  = ra;
        rd_addrA  = rdA;
        rd_addrB  = rdB;
    endtask

    initial begin
        logic [1:0] hv;
        logic [3:0] ha [2];
        logic [7:0] hd [2];

        rst_n = 1'b0;
        applyStimulus(2'b11, 4'd1, 8'hA1, 4'd2, 8'hB2, 1'b0, 4'd0, 4'd0, 4'd0);

        // Reset holds everything quiet even with both requesters valid.
        repeat (3) begin
            nextCycle();
            atSample();
            checkOutput("rst_req_ready", req_ready, 2'b00);
            checkOutput("rst_rf_wr_en", rf_wr_en, 1'b0);
            checkOutput("rst_rsv_ready", rsv_ready, 1'b0);
        end

        // Release: requester 0 first, then strict alternation with lagging writes.
        nextCycle(); rst_n = 1'b1; atSample();
        checkOutput("c0_ready", req_ready, 2'b01);
        checkOutput("c0_wr_en", rf_wr_en, 1'b0);
        nextCycle(); atSample();
        checkOutput("c1_ready", req_ready, 2'b10);
        checkOutput("c1_wr_en", rf_wr_en, 1'b1);
        checkOutput("c1_wr_addr", rf_wr_addr, 4'd1);
        checkOutput("c1_wr_data", rf_dat_out, 8'hA1);
        nextCycle(); atSample();
        checkOutput("c2_ready", req_ready, 2'b01);
        checkOutput("c2_wr_addr", rf_wr_addr, 4'd2);
        checkOutput("c2_wr_data", rf_dat_out, 8'hB2);
        nextCycle(); atSample();
        checkOutput("c3_ready", req_ready, 2'b10);
        checkOutput("c3_wr_addr", rf_wr_addr, 4'd1);
        nextCycle(); applyStimulus(2'b00, 4'd1, 8'hA1, 4'd2, 8'hB2, 1'b0, 4'd0, 4'd0, 4'd0); atSample();
        checkOutput("c4_ready", req_ready, 2'b00);
        checkOutput("c4_wr_en", rf_wr_en, 1'b1);
        checkOutput("c4_wr_addr", rf_wr_addr, 4'd2);
        nextCycle(); atSample();
        checkOutput("c5_wr_en", rf_wr_en, 1'b0);

        // Reserve r3, write it from requester 1, watch the hazard drop after the write.
        nextCycle(); applyStimulus(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 1'b1, 4'd3, 4'd3, 4'd0); atSample();
        checkOutput("rsv3_ready", rsv_ready, 1'b1);
        checkOutput("rsv3_haz_pre", haz_a, 1'b0);
        nextCycle(); applyStimulus(2'b10, 4'd0, 8'h00, 4'd3, 8'h5C, 1'b0, 4'd0, 4'd3, 4'd0); atSample();
        checkOutput("r3_haz_set", haz_a, 1'b1);
        checkOutput("r3_req_ready", req_ready, 2'b10);
        nextCycle(); applyStimulus(2'b00, 4'd0, 8'h00, 4'd3, 8'h5C, 1'b0, 4'd0, 4'd3, 4'd0); atSample();
        checkOutput("r3_wr_data", rf_dat_out, 8'h5C);
        checkOutput("r3_haz_wr", haz_a, 1'b1);
        nextCycle(); atSample();
        checkOutput("r3_haz_clr", haz_a, 1'b0);

        // WAW: a second reservation of r3 waits for the pending write to retire.
        nextCycle(); applyStimulus(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 1'b1, 4'd3, 4'd3, 4'd0); atSample();
        checkOutput("waw_first", rsv_ready, 1'b1);
        nextCycle(); applyStimulus(2'b01, 4'd3, 8'h77, 4'd0, 8'h00, 1'b1, 4'd3, 4'd3, 4'd0); atSample();
        checkOutput("waw_wait", rsv_ready, 1'b0);
        nextCycle(); applyStimulus(2'b00, 4'd3, 8'h77, 4'd0, 8'h00, 1'b1, 4'd3, 4'd3, 4'd0); atSample();
        checkOutput("waw_wait_wr", rsv_ready, 1'b0);
        nextCycle(); atSample();
        checkOutput("waw_go", rsv_ready, 1'b1);
        nextCycle(); applyStimulus(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 1'b0, 4'd0, 4'd3, 4'd0); atSample();
        checkOutput("waw_busy_again", haz_a, 1'b1);

        // Set wins: reserve r5 in the very cycle a write to idle r5 retires.
        nextCycle(); applyStimulus(2'b01, 4'd5, 8'h55, 4'd0, 8'h00, 1'b0, 4'd0, 4'd0, 4'd5); atSample();
        checkOutput("sw_haz_pre", haz_b, 1'b0);
        nextCycle(); applyStimulus(2'b00, 4'd5, 8'h55, 4'd0, 8'h00, 1'b1, 4'd5, 4'd0, 4'd5); atSample();
        checkOutput("sw_wr_addr", rf_wr_addr, 4'd5);
        checkOutput("sw_rsv_ready", rsv_ready, 1'b1);
        nextCycle(); applyStimulus(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 1'b0, 4'd0, 4'd0, 4'd5); atSample();
        checkOutput("sw_haz_post", haz_b, 1'b1);

        // Out-of-range request: granted, never written, error latches.
        nextCycle(); applyStimulus(2'b01, 4'd9, 8'h33, 4'd0, 8'h00, 1'b0, 4'd0, 4'd9, 4'd0); atSample();
        checkOutput("oor_ready", req_ready, 2'b01);
        checkOutput("oor_err_pre", err_addr, 1'b0);
        checkOutput("oor_haz", haz_a, 1'b0);
        nextCycle(); applyStimulus(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 1'b1, 4'd9, 4'd9, 4'd0); atSample();
        checkOutput("oor_wr_en", rf_wr_en, 1'b0);
        checkOutput("oor_err", err_addr, 1'b1);
        checkOutput("oor_rsv_ready", rsv_ready, 1'b1);
        repeat (3) begin
            nextCycle(); applyStimulus(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 1'b0, 4'd0, 4'd1, 4'd2); atSample();
            checkOutput("oor_sticky", err_addr, 1'b1);
        end

        // Reset right after an accept drops the write and restores prio 0.
        nextCycle(); applyStimulus(2'b01, 4'd4, 8'h44, 4'd0, 8'h00, 1'b1, 4'd2, 4'd3, 4'd2); atSample();
        checkOutput("rr_accept", req_ready, 2'b01);
        nextCycle(); rst_n = 1'b0; applyStimulus(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 1'b0, 4'd0, 4'd3, 4'd2); atSample();
        checkOutput("rr_inflight", rf_wr_en, 1'b1);
        checkOutput("rr_ready0", req_ready, 2'b00);
        nextCycle(); rst_n = 1'b1; applyStimulus(2'b11, 4'd6, 8'h66, 4'd7, 8'h77, 1'b0, 4'd0, 4'd3, 4'd2); atSample();
        checkOutput("rr_prio0", req_ready, 2'b01);
        checkOutput("rr_wr_en", rf_wr_en, 1'b0);
        checkOutput("rr_haz_a", haz_a, 1'b0);
        checkOutput("rr_haz_b", haz_b, 1'b0);
        checkOutput("rr_err", err_addr, 1'b0);

        // Randomized traffic: requesters hold their payload until granted.
        hv    = 2'b11;
        ha[0] = 4'd6; hd[0] = 8'h66;
        ha[1] = 4'd7; hd[1] = 8'h77;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            nextCycle();
            for (int r = 0; r < 2; r++) begin
                if (lastGrant[r] || !hv[r]) begin
                    hv[r] = ($urandom_range(0, 1) == 1);
                    ha[r] = ($urandom_range(0, 9) == 0) ? 4'(8 + $urandom_range(0, 7))
                                                        : 4'($urandom_range(0, 7));
                    hd[r] = 8'($urandom_range(0, 255));
                end
            end
            rst_n = ($urandom_range(0, 199) != 0);
            applyStimulus(hv, ha[0], hd[0], ha[1], hd[1],
                          ($urandom_range(0, 9) < 3),
                          ($urandom_range(0, 11) == 0) ? 4'(8 + $urandom_range(0, 7))
                                                       : 4'($urandom_range(0, 7)),
                          4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
        end
        nextCycle();
        atSample();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
